// File: rtl/score_pulse_gen_pkg.sv
// Shared definitions for the score pulse generator: state encoding and
// default timing / saturation parameters.
package score_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam int unsigned DEF_HIGH_CYCLES = 32'd4;
    localparam int unsigned DEF_LOW_CYCLES  = 32'd4;
    localparam int unsigned DEF_PEND_MAX    = 32'd31;

    // Phase counter counts down to zero, so a phase of N cycles loads N-1.
    function automatic logic [3:0] phase_load(input int unsigned cycles);
        return 4'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/score_pulse_gen_sat_accum.sv
// 5-bit saturating accumulator: adds up to 15 and optionally removes one,
// clipping at MAX and flagging when the clip happened.
module sat_accum
    import score_pulse_gen_pkg::*;
#(
    parameter int unsigned MAX = DEF_PEND_MAX
) (
    input  logic [4:0] acc_i,
    input  logic [3:0] add_i,
    input  logic       dec_i,
    output logic [4:0] sum_o,
    output logic       sat_o
);

    logic [5:0] raw_s;
    logic [5:0] net_s;

    assign raw_s = {1'b0, acc_i} + {2'b00, add_i};

    // Apply the decrement (never below zero), then clip to MAX.
    always_comb begin
        net_s = raw_s;
        if (dec_i && (raw_s != 6'd0)) begin
            net_s = raw_s - 6'd1;
        end else begin
            net_s = raw_s;
        end
        if (net_s > 6'(MAX)) begin
            sum_o = 5'(MAX);
            sat_o = 1'b1;
        end else begin
            sum_o = net_s[4:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/score_pulse_gen.sv
// Converts point requests into a train of score_update pulses (one falling
// edge per point) with a stable enable, for a downstream edge-counting scorer.
module score_pulse_gen
    import score_pulse_gen_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
    parameter int unsigned PEND_MAX    = DEF_PEND_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] points,
    output logic       ack,
    output logic       score_update,
    output logic       en,
    output logic       busy,
    output logic [4:0] pending,
    output logic       overflow
);

    localparam logic [3:0] HIGH_LOAD = phase_load(HIGH_CYCLES);
    localparam logic [3:0] LOW_LOAD  = phase_load(LOW_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [4:0] pending_q, pending_d;
    logic       ack_q, su_q, en_q, busy_q, overflow_q;
    logic [3:0] add_pts_s;
    logic       emit_s;
    logic       sat_s;

    assign add_pts_s = req ? points : 4'd0;
    // A point leaves the pending pool on the last HIGH cycle (the falling edge).
    assign emit_s    = (state_q == ST_HIGH) && (phase_q == 4'd0);

    sat_accum #(
        .MAX (PEND_MAX)
    ) u_pending_acc (
        .acc_i (pending_q),
        .add_i (add_pts_s),
        .dec_i (emit_s),
        .sum_o (pending_d),
        .sat_o (sat_s)
    );

    // Next-state and phase reload; points accepted this edge count toward starting a pulse.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_d != 5'd0) begin
                    state_d = ST_HIGH;
                    phase_d = HIGH_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    phase_d = 4'd0;
                end
            end
            ST_HIGH: begin
                if (phase_q == 4'd0) begin
                    state_d = ST_LOW;
                    phase_d = LOW_LOAD;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_LOW: begin
                if (phase_q != 4'd0) begin
                    phase_d = phase_q - 4'd1;
                end else if (pending_d != 5'd0) begin
                    state_d = ST_HIGH;
                    phase_d = HIGH_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    phase_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    // FSM state, pending pool and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= 4'd0;
            pending_q  <= 5'd0;
            ack_q      <= 1'b0;
            su_q       <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            ack_q      <= req;
            su_q       <= (state_d == ST_HIGH);
            en_q       <= (state_d != ST_IDLE);
            busy_q     <= (state_d != ST_IDLE) || (pending_d != 5'd0);
            overflow_q <= overflow_q | sat_s;
        end
    end

    assign ack          = ack_q;
    assign score_update = su_q;
    assign en           = en_q;
    assign busy         = busy_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_score_pulse_gen.sv
// Self-checking bench for score_pulse_gen: directed scenarios plus random
// requests, compared each cycle against a pulse-timeline reference model.
module tb_score_pulse_gen;

    localparam int H    = 4;
    localparam int L    = 4;
    localparam int PMAX = 31;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [3:0] points;
    logic       ack, score_update, en, busy, overflow;
    logic [4:0] pending;

    score_pulse_gen dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .points       (points),
        .ack          (ack),
        .score_update (score_update),
        .en           (en),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: pending pool plus the cycle at which the current pulse rose.
    int m_pend;
    int m_rise;
    bit m_active;
    bit m_ovf;
    bit m_ack;

    int falls;
    bit prev_su;
    int mod10;

    logic [9:0] obs_v;
    logic [9:0] exp_v;

    task automatic model_reset();
        m_pend   = 0;
        m_rise   = 0;
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_ack    = 1'b0;
        prev_su  = 1'b0;
        falls    = 0;
    endtask

    // Pulse occupies cycles [rise, rise+H) high, then [rise+H, rise+H+L) low.
    task automatic model_edge(input bit r, input int p);
        int  k;
        bit  emit;
        int  sum;
        k    = cyc;
        emit = m_active && (k == m_rise + H - 1);
        sum  = m_pend + (r ? p : 0) - (emit ? 1 : 0);
        if (sum > PMAX) begin
            sum   = PMAX;
            m_ovf = 1'b1;
        end
        m_pend = sum;
        if (m_active) begin
            if (k == m_rise + H + L - 1) begin
                if (m_pend > 0) m_rise = k + 1;
                else            m_active = 1'b0;
            end
        end else if (m_pend > 0) begin
            m_active = 1'b1;
            m_rise   = k + 1;
        end
        m_ack = r;
    endtask

    task automatic step(input bit r, input logic [3:0] p);
        bit su_e;
        bit busy_e;
        @(negedge clk);
        req    = r;
        points = p;
        @(posedge clk);
        model_edge(r, int'(p));
        cyc++;
        #1;
        su_e   = m_active && (cyc < m_rise + H);
        busy_e = m_active || (m_pend != 0);
        obs_v  = {ack, score_update, en, busy, pending, overflow};
        exp_v  = {m_ack, su_e, m_active, busy_e, 5'(m_pend), m_ovf};
        if (prev_su && !score_update) begin
            falls++;
            if (en) mod10 = (mod10 + 1) % 10;
        end
        prev_su = score_update;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req    = 1'b1;
        points = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack, score_update, en, busy, pending, overflow} !== 10'd0) begin
            $display("FAIL reset_state got=%b want=%b", {ack, score_update, en, busy, pending, overflow}, 10'd0);
        end else passed++;
        req    = 1'b0;
        points = 4'd0;
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_burst();
        falls = 0;
        step(1'b1, 4'd3);
        checks++;
        if (ack !== 1'b1 || pending !== 5'd3) begin
            $display("FAIL single_first_edge ack=%b pending=%0d want ack=1 pending=3", ack, pending);
        end else passed++;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 4'd0);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL single_cycle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
        checks++;
        if (falls !== 3 || busy !== 1'b0 || en !== 1'b0) begin
            $display("FAIL single_summary falls=%0d busy=%b en=%b want falls=3 busy=0 en=0", falls, busy, en);
        end else passed++;
    endtask

    task automatic test_merge();
        falls = 0;
        step(1'b1, 4'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0);
        step(1'b1, 4'd5);
        checks++;
        if (pending !== 5'd6) begin
            $display("FAIL merge_pending got=%0d want=6", pending);
        end else passed++;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 4'd0);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL merge_cycle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
        checks++;
        if (falls !== 7) begin
            $display("FAIL merge_falls got=%0d want=7", falls);
        end else passed++;
    endtask

    task automatic test_zero_points();
        step(1'b1, 4'd0);
        checks++;
        if ({ack, score_update, en, busy, pending} !== {4'b1000, 5'd0}) begin
            $display("FAIL zero_points got=%b want=%b", {ack, score_update, en, busy, pending}, {4'b1000, 5'd0});
        end else passed++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL zero_cycle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
    endtask

    task automatic test_saturation();
        falls = 0;
        step(1'b1, 4'd15);
        step(1'b1, 4'd15);
        step(1'b1, 4'd5);
        checks++;
        if (pending !== 5'd31 || overflow !== 1'b1) begin
            $display("FAIL sat_pending got pending=%0d ovf=%b want 31/1", pending, overflow);
        end else passed++;
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 4'd0);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL sat_cycle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
        checks++;
        if (falls !== 31 || busy !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL sat_summary falls=%0d busy=%b ovf=%b want 31/0/1", falls, busy, overflow);
        end else passed++;
    endtask

    task automatic test_reset_mid_pulse();
        step(1'b1, 4'd4);
        for (int i = 0; i < 9; i++) step(1'b0, 4'd0);
        checks++;
        if (score_update !== 1'b1 || pending !== 5'd3) begin
            $display("FAIL midrst_pre su=%b pending=%0d want su=1 pending=3", score_update, pending);
        end else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({score_update, en, busy, pending, overflow} !== 9'd0) begin
            $display("FAIL midrst_drop got=%b want=%b", {score_update, en, busy, pending, overflow}, 9'd0);
        end else passed++;
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd0);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL midrst_cycle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
        checks++;
        if (falls !== 0) begin
            $display("FAIL midrst_falls got=%0d want=0", falls);
        end else passed++;
    endtask

    task automatic test_mod10();
        mod10 = 0;
        step(1'b1, 4'd12);
        for (int i = 0; i < 100; i++) step(1'b0, 4'd0);
        checks++;
        if (mod10 !== 2) begin
            $display("FAIL mod10_counter got=%0d want=2", mod10);
        end else passed++;
    endtask

    task automatic test_random();
        bit         r;
        logic [3:0] p;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 9) == 0);
            p = 4'($urandom_range(0, 15));
            step(r, p);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL random_cycle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
        for (int i = 0; i < 400 && (m_active || m_pend != 0); i++) begin
            step(1'b0, 4'd0);
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL random_drain cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
            end else passed++;
        end
        checks++;
        if (busy !== 1'b0 || en !== 1'b0) begin
            $display("FAIL random_idle busy=%b en=%b want 0/0", busy, en);
        end else passed++;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 1'b0;
        points = 4'd0;
        model_reset();
        mod10  = 0;
        test_reset();
        test_single_burst();
        test_merge();
        test_zero_points();
        test_saturation();
        test_reset_mid_pulse();
        test_mod10();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
